// File: rtl/seven_segs_scan_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_segs_scan_if : value/enable in, digit-drive bus out        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface seven_segs_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] Value;
  logic                    Enable;
  logic [3:0]              Digit;
  logic                    EnableSegs;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic                    FrameDone;

  modport master (
    output Value,
    output Enable,
    input  Digit,
    input  EnableSegs,
    input  DigitEn,
    input  FrameDone
  );

  modport slave (
    input  Value,
    input  Enable,
    output Digit,
    output EnableSegs,
    output DigitEn,
    output FrameDone
  );
endinterface
`default_nettype wire

// File: rtl/seven_segs_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_segs_scan : multiplexed digit scanner with frame snapshot  |
// | Option macro: SEVEN_SEGS_LEADING_ZERO_BLANK_EN    Revision: 1.0  |
// +------------------------------------------------------------------+
module seven_segs_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  wire logic        Clk,
  input  wire logic        Rst_n,
  seven_segs_scan_if.slave bus
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [VAL_W-1:0]   shadow, shadow_nxt;
  logic               frame_done_nxt;

  logic [3:0]            digit_nxt;
  logic                  segs_nxt;
  logic [NUM_DIGITS-1:0] digit_en_nxt;
  logic                  suppress;

  logic [3:0] nib [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign nib[i] = shadow[4*i +: 4];
  end

`ifdef SEVEN_SEGS_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  logic [NUM_DIGITS-1:0] upper_zero;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign upper_zero[i] = (shadow[VAL_W-1:4*i] == '0);
  end

  assign suppress = (idx != '0) && upper_zero[idx];
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    shadow_nxt     = shadow;
    frame_done_nxt = 1'b0;

    if (!bus.Enable) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          shadow_nxt = bus.Value;
          idx_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = S_BLANK;
        end
        S_BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state_nxt = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = S_BLANK;
            if (idx == IDX_LAST) begin
              // Frame boundary: the only point where a new value is captured.
              idx_nxt        = '0;
              shadow_nxt     = bus.Value;
              frame_done_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Drive levels follow the current state one cycle later; a sampled Enable=0
  // darkens the display at the same edge that returns the FSM to IDLE.
  always_comb begin
    digit_nxt    = 4'h0;
    segs_nxt     = 1'b0;
    digit_en_nxt = '0;
    if (bus.Enable && (state == S_SHOW)) begin
      digit_nxt = nib[idx];
      if (!suppress) begin
        segs_nxt     = 1'b1;
        digit_en_nxt = NUM_DIGITS'(1) << idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bus.Digit      <= 4'h0;
      bus.EnableSegs <= 1'b0;
      bus.DigitEn    <= '0;
      bus.FrameDone  <= 1'b0;
    end else begin
      bus.Digit      <= digit_nxt;
      bus.EnableSegs <= segs_nxt;
      bus.DigitEn    <= digit_en_nxt;
      bus.FrameDone  <= frame_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segs_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seven_segs_scan : frame-position model vs. scanner outputs    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_seven_segs_scan;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = ND * SD;

  logic Clk = 1'b0;
  logic Rst_n;

  int total = 0;
  int bad   = 0;

  seven_segs_scan_if #(.NUM_DIGITS(ND)) bus ();

  seven_segs_scan #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BL)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit shown(input int d, input logic [15:0] s);
`ifdef SEVEN_SEGS_LEADING_ZERO_BLANK_EN
    return (d == 0) || ((s >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  // Model: position within the frame since scanning started, plus the frame snapshot.
  bit          started = 0;
  bit          run     = 0;
  int          pos     = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  e_digit  = '0;
  logic        e_lit    = 1'b0;
  logic [3:0]  e_en     = '0;
  logic        e_fd     = 1'b0;

  always @(posedge Clk) begin
    int d;
    int off;
    started = 1;
    e_digit = '0;
    e_lit   = 1'b0;
    e_en    = '0;
    e_fd    = 1'b0;
    if (!Rst_n || !bus.Enable) begin
      run = 0;
    end else if (!run) begin
      run      = 1;
      pos      = 0;
      m_shadow = bus.Value;
    end else begin
      d   = pos / SD;
      off = pos % SD;
      if (off >= BL && shown(d, m_shadow)) begin
        e_lit   = 1'b1;
        e_en    = 4'(1 << d);
        e_digit = m_shadow[4*d +: 4];
      end
      if (pos == FRAME - 1) begin
        e_fd     = 1'b1;
        m_shadow = bus.Value;
      end
      pos = (pos + 1) % FRAME;
    end
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("digit_en", bus.DigitEn, e_en);
      chk("enable_segs", bus.EnableSegs, e_lit);
      chk("frame_done", bus.FrameDone, e_fd);
      if (e_lit) chk("digit", bus.Digit, e_digit);
      chk("onehot", ($countones(bus.DigitEn) <= 1), 1);
      chk("segs_vs_en", bus.EnableSegs, (bus.DigitEn != '0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    int lz;
    v  = 16'($urandom);
    lz = $urandom_range(0, 4);
    for (int i = 0; i < lz; i++) v[15 - 4*i -: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    Rst_n      = 1'b0;
    bus.Enable = 1'b1;
    bus.Value  = 16'h1234;
    tick(3);
    chk("rst_digit_en", bus.DigitEn, 4'b0000);
    chk("rst_segs", bus.EnableSegs, 1'b0);
    chk("rst_digit", bus.Digit, 4'h0);
    chk("rst_fd", bus.FrameDone, 1'b0);

    Rst_n = 1'b1;
    tick(1);
    tick(3);
    chk("lit0_en", bus.DigitEn, 4'b0001);
    chk("lit0_digit", bus.Digit, 4'h4);
    tick(8);
    chk("lit1_en", bus.DigitEn, 4'b0010);
    chk("lit1_digit", bus.Digit, 4'h3);
    bus.Value = 16'hABCD;
    tick(8);
    chk("snap2_en", bus.DigitEn, 4'b0100);
    chk("snap2_digit", bus.Digit, 4'h2);
    tick(8);
    chk("snap3_en", bus.DigitEn, 4'b1000);
    chk("snap3_digit", bus.Digit, 4'h1);
    tick(5);
    chk("fd_pulse", bus.FrameDone, 1'b1);
    tick(1);
    chk("fd_single", bus.FrameDone, 1'b0);
    tick(2);
    chk("new0_digit", bus.Digit, 4'hD);
    tick(8);
    chk("new1_digit", bus.Digit, 4'hC);
    tick(8);
    chk("new2_digit", bus.Digit, 4'hB);

    bus.Enable = 1'b0;
    tick(1);
    chk("dis_en", bus.DigitEn, 4'b0000);
    chk("dis_segs", bus.EnableSegs, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("dis_no_fd", bus.FrameDone, 1'b0);
    end

    bus.Value  = 16'h0050;
    bus.Enable = 1'b1;
    tick(1);
    tick(3);
    chk("lz0_en", bus.DigitEn, 4'b0001);
    chk("lz0_digit", bus.Digit, 4'h0);
    tick(8);
    chk("lz1_en", bus.DigitEn, 4'b0010);
    chk("lz1_digit", bus.Digit, 4'h5);
    tick(8);
`ifdef SEVEN_SEGS_LEADING_ZERO_BLANK_EN
    chk("lz2_en", bus.DigitEn, 4'b0000);
`else
    chk("lz2_en", bus.DigitEn, 4'b0100);
`endif

    for (int i = 0; i < 2000; i++) begin
      Rst_n      = ($urandom_range(0, 199) != 0);
      bus.Enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) bus.Value = rand_value();
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
